// File: rtl/ring_osc_meas_ctrl.sv
// ring_osc_meas_ctrl: clk-domain sequencer for a tapped ring oscillator and its
// osc-clocked edge counter. It selects a tap, opens a gate window, lets the
// counter freeze, captures the held count with a two-sample agreement check,
// and presents each result on a valid/ready port. It handles a single tap or
// sweeps taps 0..7.
// Optional feature macro RING_OSC_MEAS_MINMAX_EN adds stat_min/stat_max
// tracking of error-free accepted counts.
module ring_osc_meas_ctrl #(
    parameter int CNT_W   = 15,
    parameter int WIN_W   = 16,
    parameter int SETTLE  = 4,
    parameter int MAX_TRY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sweep,
    input  logic [2:0]       tap_cfg,
    input  logic [WIN_W-1:0] win_len,
    output logic             osc_en,
    output logic [2:0]       osc_tap,
    input  logic [CNT_W-1:0] osc_count,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_tap,
    output logic [CNT_W-1:0] res_count,
    output logic             res_err
`ifdef RING_OSC_MEAS_MINMAX_EN
    ,
    output logic [CNT_W-1:0] stat_min,
    output logic [CNT_W-1:0] stat_max
`endif
);

    localparam int TRY_W = $clog2(MAX_TRY + 1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE - 1);
    localparam logic [TRY_W-1:0] TRY_LAST    = TRY_W'(MAX_TRY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_HOLD,
        S_CAPTURE,
        S_PRESENT
    } state_t;

    state_t             state_reg;
    logic               sweep_reg;
    logic [WIN_W-1:0]   win_reg;
    logic [WIN_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   s0_reg;
    logic [TRY_W-1:0]   try_reg;

    // A new run is accepted only from IDLE and only when not aborted;
    // a result is accepted on the handshake unless abort overrides it.
    logic start_acc;
    logic hs_acc;
    assign start_acc = (state_reg == S_IDLE) && start && !abort;
    assign hs_acc    = (state_reg == S_PRESENT) && res_valid && res_ready && !abort;

    // Measurement sequencer: all control outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            sweep_reg <= 1'b0;
            win_reg   <= '0;
            cnt_reg   <= '0;
            s0_reg    <= '0;
            try_reg   <= '0;
            osc_en    <= 1'b0;
            osc_tap   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            res_tap   <= 3'd0;
            res_count <= '0;
            res_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_reg != S_IDLE && abort) begin
                // Abort: drop everything, keep osc_tap, no done pulse.
                state_reg <= S_IDLE;
                osc_en    <= 1'b0;
                res_valid <= 1'b0;
                busy      <= 1'b0;
                cnt_reg   <= '0;
                try_reg   <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start_acc) begin
                            sweep_reg <= sweep;
                            win_reg   <= (win_len == '0) ? WIN_W'(1) : win_len;
                            osc_tap   <= sweep ? 3'd0 : tap_cfg;
                            busy      <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (cnt_reg == SETTLE_LAST) begin
                            cnt_reg   <= '0;
                            osc_en    <= 1'b1;
                            state_reg <= S_GATE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    S_GATE: begin
                        if (cnt_reg == win_reg - 1'b1) begin
                            cnt_reg   <= '0;
                            osc_en    <= 1'b0;
                            state_reg <= S_HOLD;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (cnt_reg == SETTLE_LAST) begin
                            cnt_reg   <= '0;
                            try_reg   <= '0;
                            state_reg <= S_CAPTURE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        // First cycle takes s0; each later cycle compares s0
                        // against the fresh sample (s1) until they agree.
                        if (cnt_reg == '0) begin
                            s0_reg  <= osc_count;
                            cnt_reg <= WIN_W'(1);
                        end else if (s0_reg == osc_count) begin
                            res_count <= osc_count;
                            res_err   <= 1'b0;
                            res_tap   <= osc_tap;
                            res_valid <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= S_PRESENT;
                        end else if (try_reg == TRY_LAST) begin
                            res_count <= osc_count;
                            res_err   <= 1'b1;
                            res_tap   <= osc_tap;
                            res_valid <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= S_PRESENT;
                        end else begin
                            s0_reg  <= osc_count;
                            try_reg <= try_reg + 1'b1;
                        end
                    end
                    S_PRESENT: begin
                        if (hs_acc) begin
                            res_valid <= 1'b0;
                            if (sweep_reg && osc_tap != 3'd7) begin
                                osc_tap   <= osc_tap + 3'd1;
                                cnt_reg   <= '0;
                                state_reg <= S_ARM;
                            end else begin
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                state_reg <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        osc_en    <= 1'b0;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RING_OSC_MEAS_MINMAX_EN
    // Running min/max of error-free accepted counts, re-seeded at each start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_min <= '0;
            stat_max <= '0;
        end else if (start_acc) begin
            stat_min <= '1;
            stat_max <= '0;
        end else if (hs_acc && !res_err) begin
            if (res_count < stat_min) stat_min <= res_count;
            if (res_count > stat_max) stat_max <= res_count;
        end
    end
`endif

endmodule
